// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Brief    : Parametrised inter-stage pipeline register with valid/ready
//             handshake, 2-entry skid buffer, flush with NOP injection and
//             an optional saturating stall-cycle counter (STAGE_PERF_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int                DATA_W  = 64,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Occupancy: main register only, or main plus skid register.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_accept;
    logic              w_drain;

    // Ready depends only on registered occupancy, so no dn_ready_i -> up_ready_o path.
    assign up_ready_o = rst_i & (r_state != c_FULL);
    assign dn_valid_o = (r_state != c_EMPTY);
    assign dn_data_o  = r_main;
    assign w_accept   = up_valid_i & up_ready_o;
    assign w_drain    = dn_valid_o & dn_ready_i;

    // Next occupancy and register contents; main falls back to NOP when it empties.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            c_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = c_ONE;
                    w_main_nxt  = up_data_i;
                end
            end
            c_ONE: begin
                if (w_accept && w_drain) begin
                    w_main_nxt  = up_data_i;
                end else if (w_accept) begin
                    w_state_nxt = c_FULL;
                    w_skid_nxt  = up_data_i;
                end else if (w_drain) begin
                    w_state_nxt = c_EMPTY;
                    w_main_nxt  = NOP_VAL;
                end
            end
            c_FULL: begin
                if (w_drain) begin
                    w_state_nxt = c_ONE;
                    w_main_nxt  = r_skid;
                    w_skid_nxt  = NOP_VAL;
                end
            end
            default: begin
                w_state_nxt = c_EMPTY;
                w_main_nxt  = NOP_VAL;
                w_skid_nxt  = NOP_VAL;
            end
        endcase
    end

    // State and payload registers; reset beats flush, flush beats any transfer.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            r_state <= c_EMPTY;
            r_main  <= NOP_VAL;
            r_skid  <= NOP_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

`ifdef STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count cycles where a valid payload is held back; saturate, cleared by reset only.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (dn_valid_o && !dn_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_buf
//  Brief    : Self-checking bench for pipe_stage_buf against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int            DW  = 32;
    localparam int            CW  = 4;
    localparam logic [DW-1:0] NOP = 32'hDEAD_BEEF;
`ifdef STAGE_PERF_EN
    localparam int            PERF = 1;
`else
    localparam int            PERF = 0;
`endif
    localparam int            CMAX = (1 << CW) - 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          flush    = 1'b0;
    logic          up_valid = 1'b0;
    logic [DW-1:0] up_data  = '0;
    logic          dn_ready = 1'b0;
    logic          up_ready;
    logic          dn_valid;
    logic [DW-1:0] dn_data;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of held payloads (capacity 2) and a stall count.
    logic [DW-1:0] q[$];
    int            mcnt = 0;

    pipe_stage_buf #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(up_ready), .up_data_i(up_data),
        .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_data_o(dn_data),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic exp_valid();
        return q.size() > 0;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (q.size() > 0) ? q[0] : NOP;
    endfunction

    function automatic logic exp_ready();
        return rst_n && (q.size() < 2);
    endfunction

    // Apply inputs shortly after the falling edge, leaving time to settle.
    task automatic drive(input logic r, input logic f, input logic uv,
                         input logic [DW-1:0] d, input logic dr);
        rst_n = r; flush = f; up_valid = uv; up_data = d; dn_ready = dr;
        #1;
    endtask

    // Advance one clock and update the model with the transfer rules.
    task automatic tick();
        int sz;
        @(posedge clk);
        sz = q.size();
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (PERF != 0 && sz > 0 && !dn_ready && mcnt < CMAX) mcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (sz > 0 && dn_ready) void'(q.pop_front());
                if (up_valid && sz < 2) q.push_back(up_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1234, 1'b1);
            if (i == 1) begin
                checks++;
                if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", dn_valid); end
                checks++;
                if (dn_data !== NOP) begin errors++; $display("FAIL reset_data: got %h want %h", dn_data, NOP); end
                checks++;
                if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
            end
            checks++;
            if (up_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", up_ready); end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", up_ready); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 1'b0, (i <= 8), DW'(i), 1'b1);
            if (i > 1) begin
                checks++;
                if (dn_valid !== 1'b1 || dn_data !== DW'(i - 1))
                    begin errors++; $display("FAIL stream_%0d: got v=%0b d=%h want v=1 d=%h", i - 1, dn_valid, dn_data, DW'(i - 1)); end
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (dn_valid !== 1'b0 || dn_data !== NOP) begin errors++; $display("FAIL stream_end: got v=%0b d=%h want v=0 d=%h", dn_valid, dn_data, NOP); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b, c;
        a = 32'hAAAA_0001; b = 32'hBBBB_0002; c = 32'hCCCC_0003;
        drive(1'b1, 1'b0, 1'b1, a, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, b, 1'b0);
        checks++;
        if (dn_data !== a || up_ready !== 1'b1) begin errors++; $display("FAIL bp_one: got d=%h r=%0b want d=%h r=1", dn_data, up_ready, a); end
        tick();
        drive(1'b1, 1'b0, 1'b1, c, 1'b0);
        checks++;
        if (up_ready !== 1'b0 || dn_data !== a) begin errors++; $display("FAIL bp_full: got r=%0b d=%h want r=0 d=%h", up_ready, dn_data, a); end
        tick();
        drive(1'b1, 1'b0, 1'b1, c, 1'b0);
        checks++;
        if (dn_valid !== 1'b1 || dn_data !== a) begin errors++; $display("FAIL bp_hold: got v=%0b d=%h want v=1 d=%h", dn_valid, dn_data, a); end
        tick();
        drive(1'b1, 1'b0, 1'b1, c, 1'b1);
        checks++;
        if (dn_data !== a || up_ready !== 1'b0) begin errors++; $display("FAIL bp_out_a: got d=%h r=%0b want d=%h r=0", dn_data, up_ready, a); end
        tick();
        drive(1'b1, 1'b0, 1'b1, c, 1'b1);
        checks++;
        if (dn_data !== b || up_ready !== 1'b1) begin errors++; $display("FAIL bp_out_b: got d=%h r=%0b want d=%h r=1", dn_data, up_ready, b); end
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (dn_valid !== 1'b1 || dn_data !== c) begin errors++; $display("FAIL bp_out_c: got v=%0b d=%h want v=1 d=%h", dn_valid, dn_data, c); end
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (dn_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got v=%0b want 0", dn_valid); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] d;
        d = 32'hD0D0_D0D0;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0011, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0022, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, d, 1'b0);
        checks++;
        if (up_ready !== 1'b0 || dn_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_full: got r=%0b v=%0b want r=0 v=1", up_ready, dn_valid); end
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (dn_valid !== 1'b0 || dn_data !== NOP || up_ready !== 1'b1)
            begin errors++; $display("FAIL flush_after: got v=%0b d=%h r=%0b want v=0 d=%h r=1", dn_valid, dn_data, up_ready, NOP); end
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (dn_valid !== 1'b0 || dn_data === d) begin errors++; $display("FAIL flush_drop_%0d: got v=%0b d=%h want v=0", i, dn_valid, dn_data); end
        end
        // Flush while a payload is both draining and being replaced.
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0033, 1'b1); tick();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0044, 1'b1); tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (dn_valid !== 1'b0 || dn_data !== NOP) begin errors++; $display("FAIL flush_one: got v=%0b d=%h want v=0 d=%h", dn_valid, dn_data, NOP); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(499) != 0), ($urandom_range(31) == 0),
                  $urandom_range(1), $urandom, ($urandom_range(2) != 0));
            checks++;
            if (up_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready @%0d: got %0b want %0b", i, up_ready, exp_ready()); end
            checks++;
            if (dn_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid @%0d: got %0b want %0b", i, dn_valid, exp_valid()); end
            checks++;
            if (dn_data !== exp_data()) begin errors++; $display("FAIL rand_data @%0d: got %h want %h", i, dn_data, exp_data()); end
            checks++;
            if (stall_cnt !== CW'(mcnt)) begin errors++; $display("FAIL rand_cnt @%0d: got %0d want %0d", i, stall_cnt, mcnt); end
            tick();
        end
    endtask

    task automatic test_stall_cnt();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
            if (i == 5) begin
                checks++;
                if (stall_cnt !== CW'(5 * PERF)) begin errors++; $display("FAIL cnt_mid: got %0d want %0d", stall_cnt, 5 * PERF); end
            end
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (stall_cnt !== CW'(CMAX * PERF) || dn_valid !== 1'b1)
            begin errors++; $display("FAIL cnt_sat: got %0d v=%0b want %0d v=1", stall_cnt, dn_valid, CMAX * PERF); end
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (stall_cnt !== CW'(CMAX * PERF)) begin errors++; $display("FAIL cnt_flush: got %0d want %0d", stall_cnt, CMAX * PERF); end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (stall_cnt !== '0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", stall_cnt); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        tick();
        test_streaming();
        tick();
        test_backpressure();
        tick();
        test_flush();
        tick();
        test_random();
        test_stall_cnt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
